// File: rtl/data_cal_seq.sv
// rtl/data_cal_seq.sv - issues sel 1..3 to one nibble-add datapath and bundles the three sums
// Optional response timeout enabled by DATA_CAL_SEQ_TIMEOUT_EN.
module data_cal_seq #(
  parameter int TO_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] d_in,
  output logic [15:0] cal_d,
  output logic [1:0]  cal_sel,
  input  logic [4:0]  cal_out,
  input  logic        cal_validout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_sums,
  output logic [6:0]  out_total,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] d_hold;
  logic [1:0]  step;
  logic [1:0]  rsp_cnt;
  logic [4:0]  res1, res2, res3;

  logic        active;
  logic [1:0]  rsp_nxt;
  logic [4:0]  r1n, r2n, r3n;
  logic        to_hit;
  logic        finish;

  assign in_ready = (state == IDLE);
  assign cal_d    = d_hold;
  assign active   = (state == ISSUE) || (state == WAIT);

  // Responses are counted by arrival, independent of which sel produced them.
  always_comb begin
    rsp_nxt = rsp_cnt;
    r1n     = res1;
    r2n     = res2;
    r3n     = res3;
    if (active && cal_validout && rsp_cnt != 2'd3) begin
      rsp_nxt = rsp_cnt + 2'd1;
      case (rsp_cnt)
        2'd0:    r1n = cal_out;
        2'd1:    r2n = cal_out;
        default: r3n = cal_out;
      endcase
    end
  end

  assign finish = active && ((rsp_nxt == 2'd3) || to_hit);

`ifdef DATA_CAL_SEQ_TIMEOUT_EN
  logic [4:0] to_cnt;

  // Fires on the edge where the counter reaches TO_CYC; a 3rd response on that edge wins.
  assign to_hit = active && (to_cnt + 5'd1 == 5'(TO_CYC)) && (rsp_nxt != 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= 5'd0;
      out_err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid)
        to_cnt <= 5'd0;
      else if (active)
        to_cnt <= to_cnt + 5'd1;
      if (finish)
        out_err <= to_hit;
    end
  end
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC != 0);
  assign to_hit  = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      d_hold    <= 16'd0;
      step      <= 2'd0;
      rsp_cnt   <= 2'd0;
      res1      <= 5'd0;
      res2      <= 5'd0;
      res3      <= 5'd0;
      cal_sel   <= 2'd0;
      out_valid <= 1'b0;
      out_sums  <= 15'd0;
      out_total <= 7'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_hold  <= d_in;
            step    <= 2'd1;
            cal_sel <= 2'd1;
            rsp_cnt <= 2'd0;
            res1    <= 5'd0;
            res2    <= 5'd0;
            res3    <= 5'd0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          rsp_cnt <= rsp_nxt;
          res1    <= r1n;
          res2    <= r2n;
          res3    <= r3n;
          if (state == ISSUE) begin
            if (step == 2'd3) begin
              cal_sel <= 2'd0;
              state   <= WAIT;
            end else begin
              step    <= step + 2'd1;
              cal_sel <= step + 2'd1;
            end
          end
          // Completion overrides sequencing, even mid-ISSUE.
          if (finish) begin
            cal_sel   <= 2'd0;
            out_valid <= 1'b1;
            out_sums  <= {r3n, r2n, r1n};
            out_total <= {2'b00, r1n} + {2'b00, r2n} + {2'b00, r3n};
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
